// File: rtl/regfile_write_arbiter_if.sv
// Request and port bus shared between the write requesters, the arbiter and the SRAM write ports.
// All multi-lane fields are flat packed vectors: lane i sits at [i*W +: W].
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 6,
    parameter int NPORTS = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(NPORTS + 1);

    logic                       hold;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*ADDR_W-1:0]     req_address;
    logic [NREQ*DATA_W-1:0]     req_value;
    logic [NREQ*MASK_W-1:0]     req_byteMask;
    logic [NPORTS-1:0]          wr_write;
    logic [NPORTS*ADDR_W-1:0]   wr_address;
    logic [NPORTS*DATA_W-1:0]   wr_value;
    logic [NPORTS*MASK_W-1:0]   wr_byteMask;
    logic [CNT_W-1:0]           grant_count;
    logic [15:0]                conflict_count;

    modport master (
        output hold, req_valid, req_address, req_value, req_byteMask,
        input  req_ready, wr_write, wr_address, wr_value, wr_byteMask,
               grant_count, conflict_count
    );

    modport slave (
        input  hold, req_valid, req_address, req_value, req_byteMask,
        output req_ready, wr_write, wr_address, wr_value, wr_byteMask,
               grant_count, conflict_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter granting up to NPORTS of NREQ masked register writes per cycle,
// refusing same-row collisions, with a registered SRAM port bus and a saturating collision counter.
module regfile_write_arbiter #(
    parameter int NREQ   = 6,
    parameter int NPORTS = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    regfile_write_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W  = $clog2(NPORTS + 1);

    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]                    ready;
    logic [NPORTS-1:0]                  slot_vld;
    logic [NPORTS-1:0][ADDR_W-1:0]      slot_addr;
    logic [NPORTS-1:0][DATA_W-1:0]      slot_val;
    logic [NPORTS-1:0][MASK_W-1:0]      slot_mask;
    logic [CNT_W-1:0]                   ngrant;
    logic                               collide;

    logic [NPORTS-1:0]                  wr_write_q;
    logic [NPORTS*ADDR_W-1:0]           wr_address_q;
    logic [NPORTS*DATA_W-1:0]           wr_value_q;
    logic [NPORTS*MASK_W-1:0]           wr_byteMask_q;
    logic [CNT_W-1:0]                   grant_count_q;
    logic [15:0]                        conflict_count_q;

    // Sequential scan from rr_ptr; the k-th grant is packed into port slot k.
    always_comb begin
        int                idx;
        int                ng;
        logic              v;
        logic              hit;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        ready     = '0;
        slot_vld  = '0;
        slot_addr = '0;
        slot_val  = '0;
        slot_mask = '0;
        rr_ptr_d  = rr_ptr_q;
        collide   = 1'b0;
        ng        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            v = 1'b0;
            a = '0;
            d = '0;
            m = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (i == idx) begin
                    v = bus.req_valid[i];
                    a = bus.req_address[i*ADDR_W +: ADDR_W];
                    d = bus.req_value[i*DATA_W +: DATA_W];
                    m = bus.req_byteMask[i*MASK_W +: MASK_W];
                end
            end
            hit = 1'b0;
            for (int j = 0; j < NPORTS; j++)
                if (slot_vld[j] && slot_addr[j] == a) hit = 1'b1;
            // Port exhaustion is checked first so a full bus never counts as a collision.
            if (v && !bus.hold && rst_ni && ng < NPORTS) begin
                if (hit) begin
                    collide = 1'b1;
                end else begin
                    for (int i = 0; i < NREQ; i++)
                        if (i == idx) ready[i] = 1'b1;
                    for (int j = 0; j < NPORTS; j++) begin
                        if (j == ng) begin
                            slot_vld[j]  = 1'b1;
                            slot_addr[j] = a;
                            slot_val[j]  = d;
                            slot_mask[j] = m;
                        end
                    end
                    ng       = ng + 1;
                    rr_ptr_d = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
        ngrant = CNT_W'(ng);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q         <= '0;
            wr_write_q       <= '0;
            wr_address_q     <= '0;
            wr_value_q       <= '0;
            wr_byteMask_q    <= '0;
            grant_count_q    <= '0;
            conflict_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= ngrant;
            if (collide && conflict_count_q != 16'hFFFF)
                conflict_count_q <= conflict_count_q + 16'd1;
            // Idle ports drop the enable but keep their last address/data/mask.
            for (int j = 0; j < NPORTS; j++) begin
                wr_write_q[j] <= slot_vld[j] && (|slot_mask[j]);
                if (slot_vld[j]) begin
                    wr_address_q[j*ADDR_W +: ADDR_W]  <= slot_addr[j];
                    wr_value_q[j*DATA_W +: DATA_W]    <= slot_val[j];
                    wr_byteMask_q[j*MASK_W +: MASK_W] <= slot_mask[j];
                end
            end
        end
    end

    assign bus.req_ready      = ready;
    assign bus.wr_write       = wr_write_q;
    assign bus.wr_address     = wr_address_q;
    assign bus.wr_value       = wr_value_q;
    assign bus.wr_byteMask    = wr_byteMask_q;
    assign bus.grant_count    = grant_count_q;
    assign bus.conflict_count = conflict_count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: fill/drain, collisions, zero mask, hold,
// mid-flight reset and conflict counter saturation, with hand-computed expectations.
module tb_regfile_write_arbiter;
    localparam int NREQ   = 6;
    localparam int NPORTS = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    regfile_write_arbiter_if #(.NREQ(NREQ), .NPORTS(NPORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .NPORTS(NPORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a,
                           input logic [63:0] d, input logic [7:0] m);
        bus.req_valid[i]               = v;
        bus.req_address[i*ADDR_W +: 5] = a;
        bus.req_value[i*DATA_W +: 64]  = d;
        bus.req_byteMask[i*8 +: 8]     = m;
    endtask

    task automatic all_six();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 5'(i), 64'hD000_0000_0000_0000 | 64'(i), 8'hFF);
    endtask

    task automatic none();
        bus.req_valid = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.hold = 1'b0;
        bus.req_valid = '0;
        bus.req_address = '0;
        bus.req_value = '0;
        bus.req_byteMask = '0;

        // Reset state, with requests pending
        all_six();
        #12;
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_wr_write", 64'(bus.wr_write), 64'h0);
        chk("rst_grant_count", 64'(bus.grant_count), 64'h0);
        chk("rst_conflict", 64'(bus.conflict_count), 64'h0);
        none();
        tick();
        rst_n = 1'b1;
        tick();

        // Six requests, addresses 0..5
        all_six();
        #1;
        chk("fill_ready0", 64'(bus.req_ready), 64'h0F);
        tick();
        chk("fill_wr_write1", 64'(bus.wr_write), 64'hF);
        chk("fill_addr1", 64'(bus.wr_address), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
        chk("fill_val_p2", bus.wr_value[2*64 +: 64], 64'hD000_0000_0000_0002);
        chk("fill_gc1", 64'(bus.grant_count), 64'd4);
        for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
        #1;
        chk("fill_ready1", 64'(bus.req_ready), 64'h30);
        tick();
        chk("fill_wr_write2", 64'(bus.wr_write), 64'h3);
        chk("fill_addr_p0", 64'(bus.wr_address[4:0]), 64'd4);
        chk("fill_addr_p1", 64'(bus.wr_address[9:5]), 64'd5);
        chk("fill_gc2", 64'(bus.grant_count), 64'd2);
        none();

        // Collision: requesters 0 and 2 on address 7, requester 1 on 9
        set_req(0, 1'b1, 5'd7, 64'hAAAA_0000_0000_0000, 8'hFF);
        set_req(1, 1'b1, 5'd9, 64'hBBBB_0000_0000_0000, 8'hFF);
        set_req(2, 1'b1, 5'd7, 64'hCCCC_0000_0000_0000, 8'h0F);
        #1;
        chk("coll_ready", 64'(bus.req_ready), 64'h03);
        tick();
        chk("coll_count1", 64'(bus.conflict_count), 64'd1);
        chk("coll_wr_write", 64'(bus.wr_write), 64'h3);
        chk("coll_val_p0", bus.wr_value[63:0], 64'hAAAA_0000_0000_0000);
        chk("coll_val_p1", bus.wr_value[127:64], 64'hBBBB_0000_0000_0000);
        bus.req_valid[0] = 1'b0;
        bus.req_valid[1] = 1'b0;
        #1;
        chk("coll_ready2", 64'(bus.req_ready), 64'h04);
        tick();
        chk("coll_wr_write2", 64'(bus.wr_write), 64'h1);
        chk("coll_addr2", 64'(bus.wr_address[4:0]), 64'd7);
        chk("coll_val2", bus.wr_value[63:0], 64'hCCCC_0000_0000_0000);
        chk("coll_mask2", 64'(bus.wr_byteMask[7:0]), 64'h0F);
        chk("coll_count2", 64'(bus.conflict_count), 64'd1);
        none();

        // Zero byte mask still handshakes but does not write
        set_req(3, 1'b1, 5'd12, 64'h1234, 8'h00);
        #1;
        chk("zmask_ready", 64'(bus.req_ready), 64'h08);
        tick();
        chk("zmask_wr_write", 64'(bus.wr_write), 64'h0);
        chk("zmask_gc", 64'(bus.grant_count), 64'd1);
        none();

        // Hold for three cycles; rr_ptr stays at 4
        all_six();
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_ready", 64'(bus.req_ready), 64'h0);
            tick();
            chk("hold_wr_write", 64'(bus.wr_write), 64'h0);
            chk("hold_gc", 64'(bus.grant_count), 64'h0);
        end
        bus.hold = 1'b0;
        #1;
        chk("hold_rr_ready", 64'(bus.req_ready), 64'h33);
        tick();
        chk("hold_rr_write", 64'(bus.wr_write), 64'hF);
        chk("hold_rr_addr", 64'(bus.wr_address), 64'({5'd1, 5'd0, 5'd5, 5'd4}));
        chk("pre_rst_conflict", 64'(bus.conflict_count), 64'd1);

        // Reset pulse while writes are on the port bus
        bus.req_valid = 6'b001100;
        #1;
        chk("flight_ready", 64'(bus.req_ready), 64'h0C);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", 64'(bus.wr_write), 64'h0);
        chk("mid_rst_addr", 64'(bus.wr_address), 64'h0);
        chk("mid_rst_val_p0", bus.wr_value[63:0], 64'h0);
        chk("mid_rst_gc", 64'(bus.grant_count), 64'h0);
        chk("mid_rst_conflict", 64'(bus.conflict_count), 64'h0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        rst_n = 1'b1;
        all_six();
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 64'h0F);
        tick();
        chk("post_rst_gc", 64'(bus.grant_count), 64'd4);
        none();
        tick();
        chk("sat_start", 64'(bus.conflict_count), 64'd0);

        // Two requesters on one row collide every cycle
        set_req(0, 1'b1, 5'd3, 64'h5, 8'hFF);
        set_req(1, 1'b1, 5'd3, 64'h6, 8'hFF);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(bus.conflict_count), 64'hFFFE);
        chk("sat_gc", 64'(bus.grant_count), 64'd1);
        tick();
        chk("sat_ffff", 64'(bus.conflict_count), 64'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        chk("sat_hold", 64'(bus.conflict_count), 64'hFFFF);
        none();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the four masked write ports of the 32x64 ALU register SRAM between six write requesters (ALU lanes, load return, CSR path). Each cycle it grants up to four valid/ready requests in round-robin order, assigns them to SRAM write ports, and registers the result onto the port bus. It refuses same-address collisions within a cycle so the SRAM never sees two ports writing one row. It also keeps a saturating collision counter for performance monitoring.

## Interface
- NREQ, 6, number of write requesters (2..8)
- NPORTS, 4, number of SRAM write ports driven (1..NREQ)
- ADDR_W, 5, register address width
- DATA_W, 64, data width; mask width is DATA_W/8
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  when 1, no grants this cycle
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  grant; a handshake is valid & ready in the same cycle
- req_address  in  NREQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_value  in  NREQ*DATA_W  packed write data
- req_byteMask  in  NREQ*DATA_W/8  packed byte enables, bit j enables byte j
- wr_write  out  NPORTS  port write enable to SRAM
- wr_address  out  NPORTS*ADDR_W  port address
- wr_value  out  NPORTS*DATA_W  port data
- wr_byteMask  out  NPORTS*DATA_W/8  port byte mask
- grant_count  out  $clog2(NPORTS+1)  number of handshakes in the previous cycle
- conflict_count  out  16  saturating count of cycles with at least one collision-deferred request

## Operation
- rr_ptr (range 0..NREQ-1) is the first requester examined. Scan order is rr_ptr, rr_ptr+1, … mod NREQ.
- A requester is granted only if all of the following hold:
  - its req_valid is 1;
  - hold is 0 and reset_n is 1;
  - fewer than NPORTS requesters are already granted earlier in the scan;
  - its address differs from every address already granted earlier in the scan.
- A valid requester that loses only on the address rule is collision-deferred. A valid requester that loses on port exhaustion is not counted as a collision.
- req_ready is combinational from req_valid, req_address, hold and rr_ptr. It never depends on the requester's own ready. Requesters must hold valid, address, value and mask stable until their handshake.
- The k-th granted requester in scan order (k=0..) maps to port k. Ports with k ≥ number of grants get wr_write=0.
- A granted request whose byteMask is all zero still consumes its port slot and its handshake. Its port gets wr_write=0.
- rr_ptr update:
  - at least one grant: (index of the last granted requester + 1) mod NREQ;
  - no grants (including during hold): unchanged.
- conflict_count increments by 1 in any cycle with ≥1 collision-deferred requester. It stops at 16'hFFFF.
- Reset values:
  - wr_write = 0;
  - wr_address, wr_value, wr_byteMask = 0;
  - grant_count = 0;
  - conflict_count = 0;
  - rr_ptr = 0;
  - req_ready = 0 while reset_n is 0.

## Timing
- All wr_* outputs and grant_count are registered. A handshake in cycle N appears on the port bus in cycle N+1, where the SRAM captures it on the N+1→N+2 edge.
- Throughput: up to NPORTS writes per cycle with no bubbles.
- Ports not granted in cycle N drive wr_write=0 in cycle N+1. Their address/value/mask hold the previous value.
- hold=1 in cycle N gives wr_write=0 in cycle N+1 and no req_ready in cycle N.
- reset_n assertion mid-operation immediately clears all registers. A write registered but not yet captured by the SRAM is lost.
- After reset_n deasserts, the first grants may occur in the same cycle.

## Test plan
- Six simultaneous valid requests, addresses 0..5, rr_ptr=0:
  - cycle 0: req_ready=001111;
  - cycle 1: ports 0..3 write addresses 0..3, grant_count=4, rr_ptr=4;
  - cycle 1: requesters 4 and 5 are granted;
  - cycle 2: ports 0..1 write addresses 4,5.
- Requesters 0 and 2 both target address 7, requester 1 targets address 9, rr_ptr=0:
  - ready=011 for requesters 0..2;
  - conflict_count 0→1;
  - requester 2 granted the next cycle;
  - data written follows requester 0 then requester 2.
- Single requester 3, mask 8'h00:
  - handshake occurs;
  - next cycle wr_write=0000, grant_count=1.
- hold=1 for 3 cycles with all six requesters valid:
  - req_ready=0 and wr_write=0 throughout;
  - rr_ptr unchanged.
- reset_n pulsed low while grants are in flight:
  - all outputs are 0 immediately;
  - rr_ptr=0;
  - conflict_count=0.
- Force 70000 collision cycles: conflict_count saturates at 16'hFFFF.
